// File: rtl/sdram_read_sequencer_pkg.sv
// Shared types and constants for the single-word SDRAM read sequencer.
// Commands are packed as {CS_N, RAS_N, CAS_N, WE_N}.
package sdram_read_sequencer_pkg;

    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int DQ_W  = 16;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NOP       = 4'b0111;
    localparam cmd_t CMD_ACTIVE    = 4'b0011;
    localparam cmd_t CMD_READ      = 4'b0101;
    localparam cmd_t CMD_PRECHARGE = 4'b0010;
    localparam cmd_t CMD_DESELECT  = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ACTIVATE  = 4'd1,
        ST_WAIT_RCD  = 4'd2,
        ST_READ      = 4'd3,
        ST_WAIT_CAS  = 4'd4,
        ST_CAPTURE   = 4'd5,
        ST_HOLD      = 4'd6,
        ST_PRECHARGE = 4'd7,
        ST_WAIT_RP   = 4'd8
    } state_t;

    // The bus is deselected while idle; every other non-command state idles with NOP.
    function automatic cmd_t state_cmd(input state_t st);
        cmd_t c;
        c = CMD_DESELECT;
        case (st)
            ST_IDLE:      c = CMD_DESELECT;
            ST_ACTIVATE:  c = CMD_ACTIVE;
            ST_READ:      c = CMD_READ;
            ST_PRECHARGE: c = CMD_PRECHARGE;
            ST_WAIT_RCD,
            ST_WAIT_CAS,
            ST_CAPTURE,
            ST_HOLD,
            ST_WAIT_RP:   c = CMD_NOP;
            default:      c = CMD_DESELECT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sdram_read_sequencer_cmd_encoder.sv
// Registers a packed command onto the four SDRAM command lines.
// Unknown encodings are forced to DESELECT so the device never sees a stray command.
module sdram_cmd_encoder
    import sdram_read_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd_i,
    output logic       cs_n_o,
    output logic       ras_n_o,
    output logic       cas_n_o,
    output logic       we_n_o
);

    logic [3:0] cmd_d;
    logic [3:0] cmd_q;

    // Filter the requested command to the legal set.
    always_comb begin
        cmd_d = CMD_DESELECT;
        case (cmd_i)
            CMD_NOP,
            CMD_ACTIVE,
            CMD_READ,
            CMD_PRECHARGE,
            CMD_DESELECT: cmd_d = cmd_i;
            default:      cmd_d = CMD_DESELECT;
        endcase
    end

    // Command register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= CMD_DESELECT;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = cmd_q;

endmodule

// File: rtl/sdram_read_sequencer.sv
// Single-word SDRAM read sequencer: ACTIVE, READ, capture, handshake, PRECHARGE.
// Define READ_SEQ_AUTOPRECHARGE_EN to issue READ with auto-precharge and skip PRECHARGE.
module sdram_read_sequencer
    import sdram_read_sequencer_pkg::*;
#(
    parameter int T_RCD   = 2,
    parameter int CAS_LAT = 2,
    parameter int T_RP    = 2
)(
    input  logic             CLK_48MHZ,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [BA_W-1:0]  BA_IN,
    input  logic [ROW_W-1:0] ROW_IN,
    input  logic [COL_W-1:0] COL_IN,
    output logic             NEXT,
    output logic             CS_N,
    output logic             RAS_N,
    output logic             CAS_N,
    output logic             WE_N,
    output logic [BA_W-1:0]  SD_BA,
    output logic [ROW_W-1:0] SD_A,
    input  logic [DQ_W-1:0]  SD_DQ_IN,
    output logic [DQ_W-1:0]  DATA_OUT,
    output logic             DATA_VALID,
    input  logic             DATA_READY,
    output logic             BUSY
);

    localparam int MAX_DLY = (T_RCD > CAS_LAT) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                               : ((CAS_LAT > T_RP) ? CAS_LAT : T_RP);
    localparam int CNT_W   = $clog2(MAX_DLY + 1);

    // Wait states count down to zero, so they are loaded with (delay - 2).
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] RCD_LOAD = (T_RCD   > 1) ? CNT_W'(T_RCD - 2)   : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CAS_LOAD = (CAS_LAT > 1) ? CNT_W'(CAS_LAT - 2) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] RP_LOAD  = (T_RP    > 1) ? CNT_W'(T_RP - 2)    : {CNT_W{1'b0}};

`ifdef READ_SEQ_AUTOPRECHARGE_EN
    localparam logic AP_BIT = 1'b1;
`else
    localparam logic AP_BIT = 1'b0;
`endif

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [BA_W-1:0]   ba_d, ba_q;
    logic [ROW_W-1:0]  row_d, row_q;
    logic [COL_W-1:0]  col_d, col_q;
    logic [DQ_W-1:0]   data_d, data_q;
    logic              valid_d, valid_q;
    logic              next_d, next_q;
    logic              busy_d, busy_q;
    logic [BA_W-1:0]   sd_ba_d, sd_ba_q;
    logic [ROW_W-1:0]  sd_a_d, sd_a_q;
    logic [3:0]        cmd_s;

    // Transaction FSM, address latch, delay counter and read-data holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ba_d    = ba_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        next_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE) begin
                    ba_d    = BA_IN;
                    row_d   = ROW_IN;
                    col_d   = COL_IN;
                    state_d = ST_ACTIVATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVATE: begin
                if (T_RCD > 1) begin
                    cnt_d   = RCD_LOAD;
                    state_d = ST_WAIT_RCD;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WAIT_RCD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ: begin
                if (CAS_LAT > 1) begin
                    cnt_d   = CAS_LOAD;
                    state_d = ST_WAIT_CAS;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_WAIT_CAS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                data_d  = SD_DQ_IN;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (valid_q && DATA_READY) begin
                    valid_d = 1'b0;
                    next_d  = 1'b1;
`ifdef READ_SEQ_AUTOPRECHARGE_EN
                    if (T_RP > 1) begin
                        cnt_d   = RP_LOAD;
                        state_d = ST_WAIT_RP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_PRECHARGE;
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_PRECHARGE: begin
                if (T_RP > 1) begin
                    cnt_d   = RP_LOAD;
                    state_d = ST_WAIT_RP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                valid_d = 1'b0;
            end
        endcase
    end

    // Bus address is computed from the next state so it lines up with the registered command.
    always_comb begin
        sd_ba_d = {BA_W{1'b0}};
        sd_a_d  = {ROW_W{1'b0}};
        case (state_d)
            ST_ACTIVATE: begin
                sd_ba_d = ba_d;
                sd_a_d  = row_d;
            end
            ST_READ: begin
                sd_ba_d = ba_q;
                sd_a_d  = {{(ROW_W-COL_W-2){1'b0}}, AP_BIT, 1'b0, col_q};
            end
            ST_PRECHARGE: begin
                sd_ba_d = ba_q;
                sd_a_d  = {ROW_W{1'b0}};
            end
            default: begin
                sd_ba_d = {BA_W{1'b0}};
                sd_a_d  = {ROW_W{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        cmd_s  = state_cmd(state_d);
    end

    // State and output registers.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ba_q    <= {BA_W{1'b0}};
            row_q   <= {ROW_W{1'b0}};
            col_q   <= {COL_W{1'b0}};
            data_q  <= {DQ_W{1'b0}};
            valid_q <= 1'b0;
            next_q  <= 1'b0;
            busy_q  <= 1'b0;
            sd_ba_q <= {BA_W{1'b0}};
            sd_a_q  <= {ROW_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ba_q    <= ba_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            next_q  <= next_d;
            busy_q  <= busy_d;
            sd_ba_q <= sd_ba_d;
            sd_a_q  <= sd_a_d;
        end
    end

    sdram_cmd_encoder u_cmd_enc (
        .clk     (CLK_48MHZ),
        .rst_n   (RESET),
        .cmd_i   (cmd_s),
        .cs_n_o  (CS_N),
        .ras_n_o (RAS_N),
        .cas_n_o (CAS_N),
        .we_n_o  (WE_N)
    );

    assign NEXT       = next_q;
    assign BUSY       = busy_q;
    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign SD_BA      = sd_ba_q;
    assign SD_A       = sd_a_q;

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Directed bench for sdram_read_sequencer: default timing instance plus a (3,3,1) instance.
// Honours READ_SEQ_AUTOPRECHARGE_EN when the RTL is built with it.
module tb_sdram_read_sequencer;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_DES = 4'b1111;
`ifdef READ_SEQ_AUTOPRECHARGE_EN
    localparam logic AP = 1'b1;
`else
    localparam logic AP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, rdy;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] dq;

    logic        next_a, cs_a, ras_a, cas_a, we_a, valid_a, busy_a;
    logic [1:0]  sd_ba_a;
    logic [12:0] sd_a_a;
    logic [15:0] dout_a;
    logic        next_b, cs_b, ras_b, cas_b, we_b, valid_b, busy_b;
    logic [1:0]  sd_ba_b;
    logic [12:0] sd_a_b;
    logic [15:0] dout_b;
    logic [3:0]  cmd_a, cmd_b;

    int total = 0;
    int bad = 0;
    int next_cnt_a = 0;
    int pre_cnt_a = 0;
    int n0;

    assign cmd_a = {cs_a, ras_a, cas_a, we_a};
    assign cmd_b = {cs_b, ras_b, cas_b, we_b};

    always #5 clk = ~clk;

    sdram_read_sequencer u_dut_a (
        .CLK_48MHZ(clk), .RESET(rst_n), .ENABLE(en_a),
        .BA_IN(ba), .ROW_IN(row), .COL_IN(col),
        .NEXT(next_a), .CS_N(cs_a), .RAS_N(ras_a), .CAS_N(cas_a), .WE_N(we_a),
        .SD_BA(sd_ba_a), .SD_A(sd_a_a), .SD_DQ_IN(dq),
        .DATA_OUT(dout_a), .DATA_VALID(valid_a), .DATA_READY(rdy), .BUSY(busy_a)
    );

    sdram_read_sequencer #(.T_RCD(3), .CAS_LAT(3), .T_RP(1)) u_dut_b (
        .CLK_48MHZ(clk), .RESET(rst_n), .ENABLE(en_b),
        .BA_IN(ba), .ROW_IN(row), .COL_IN(col),
        .NEXT(next_b), .CS_N(cs_b), .RAS_N(ras_b), .CAS_N(cas_b), .WE_N(we_b),
        .SD_BA(sd_ba_b), .SD_A(sd_a_b), .SD_DQ_IN(dq),
        .DATA_OUT(dout_b), .DATA_VALID(valid_b), .DATA_READY(rdy), .BUSY(busy_b)
    );

    // NEXT pulse and PRECHARGE command trace counters for instance A.
    always @(negedge clk) begin
        if (next_a === 1'b1) next_cnt_a++;
        if (cmd_a === C_PRE) pre_cnt_a++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full read on instance A; called with A idle, just after a clock edge.
    task automatic txn_a(input logic [1:0] t_ba, input logic [12:0] t_row, input logic [8:0] t_col,
                         input logic [15:0] word, input int stall, input logic en_after);
        ba = t_ba; row = t_row; col = t_col; en_a = 1'b1; dq = 16'h0000;
        rdy = (stall == 0) ? 1'b1 : 1'b0;
        tick();
        chk("act_cmd", 32'(cmd_a), 32'(C_ACT));
        chk("act_ba", 32'(sd_ba_a), 32'(t_ba));
        chk("act_row", 32'(sd_a_a), 32'(t_row));
        chk("act_busy", 32'(busy_a), 32'(1'b1));
        en_a = en_after; ba = ~t_ba; row = ~t_row; col = ~t_col;
        tick();
        chk("rcd_nop", 32'(cmd_a), 32'(C_NOP));
        tick();
        chk("rd_cmd", 32'(cmd_a), 32'(C_RD));
        chk("rd_ba", 32'(sd_ba_a), 32'(t_ba));
        chk("rd_addr", 32'(sd_a_a), 32'({2'b00, AP, 1'b0, t_col}));
        dq = 16'h1111;
        tick();
        chk("cas_nop", 32'(cmd_a), 32'(C_NOP));
        dq = 16'h2222;
        tick();
        chk("cap_valid", 32'(valid_a), 32'(1'b0));
        dq = word;
        tick();
        chk("hold_data", 32'(dout_a), 32'(word));
        chk("hold_valid", 32'(valid_a), 32'(1'b1));
        chk("hold_next", 32'(next_a), 32'(1'b0));
        dq = 16'h3333;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_data", 32'(dout_a), 32'(word));
            chk("stall_next", 32'(next_a), 32'(1'b0));
        end
        rdy = 1'b1;
        tick();
        chk("hs_next", 32'(next_a), 32'(1'b1));
        chk("hs_valid", 32'(valid_a), 32'(1'b0));
`ifdef READ_SEQ_AUTOPRECHARGE_EN
        chk("hs_nop", 32'(cmd_a), 32'(C_NOP));
`else
        chk("pre_cmd", 32'(cmd_a), 32'(C_PRE));
        chk("pre_ba", 32'(sd_ba_a), 32'(t_ba));
        chk("pre_a10", 32'(sd_a_a[10]), 32'(1'b0));
        tick();
        chk("rp_nop", 32'(cmd_a), 32'(C_NOP));
        chk("rp_next", 32'(next_a), 32'(1'b0));
`endif
        tick();
        chk("idle_busy", 32'(busy_a), 32'(1'b0));
        chk("idle_cmd", 32'(cmd_a), 32'(C_DES));
        chk("idle_next", 32'(next_a), 32'(1'b0));
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; rdy = 1'b0;
        ba = 2'd0; row = 13'd0; col = 9'd0; dq = 16'd0;
        tick();
        tick();
        chk("rst_cmd", 32'(cmd_a), 32'(C_DES));
        chk("rst_busy", 32'(busy_a), 32'(1'b0));
        chk("rst_dout", 32'(dout_a), 32'(16'h0000));
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy_a), 32'(1'b0));

        // Basic read with the documented address/data vector.
        txn_a(2'd2, 13'h1ABC, 9'h05F, 16'hBEEF, 0, 1'b0);
        // Downstream back-pressure.
        txn_a(2'd1, 13'h0123, 9'h1A0, 16'hCAFE, 10, 1'b0);

        // Four transactions with ENABLE held high and addresses disturbed mid-flight.
        n0 = next_cnt_a;
        txn_a(2'd0, 13'h1FFF, 9'h1FF, 16'h0001, 0, 1'b1);
        txn_a(2'd3, 13'h0000, 9'h000, 16'hFFFF, 0, 1'b1);
        txn_a(2'd1, 13'h0AAA, 9'h155, 16'h5A5A, 2, 1'b1);
        txn_a(2'd2, 13'h1555, 9'h0AA, 16'hA5A5, 0, 1'b0);
        chk("next_x4", 32'(next_cnt_a - n0), 32'd4);

        // Reset while waiting for CAS latency.
        n0 = next_cnt_a;
        ba = 2'd3; row = 13'h0F0F; col = 9'h0F0; rdy = 1'b1; en_a = 1'b1;
        tick();
        chk("ab_act", 32'(cmd_a), 32'(C_ACT));
        en_a = 1'b0;
        tick();
        tick();
        chk("ab_rd", 32'(cmd_a), 32'(C_RD));
        tick();
        chk("ab_cas", 32'(cmd_a), 32'(C_NOP));
        rst_n = 1'b0;
        #1;
        chk("async_cmd", 32'(cmd_a), 32'(C_DES));
        chk("async_busy", 32'(busy_a), 32'(1'b0));
        chk("async_sda", 32'(sd_a_a), 32'(13'h0000));
        chk("async_sdba", 32'(sd_ba_a), 32'(2'd0));
        chk("async_dout", 32'(dout_a), 32'(16'h0000));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("ab_cmd", 32'(cmd_a), 32'(C_DES));
        chk("ab_busy", 32'(busy_a), 32'(1'b0));
        chk("ab_valid", 32'(valid_a), 32'(1'b0));
        chk("ab_next", 32'(next_a), 32'(1'b0));
        chk("ab_dout", 32'(dout_a), 32'(16'h0000));
        chk("ab_no_next", 32'(next_cnt_a - n0), 32'd0);
        txn_a(2'd3, 13'h0F0F, 9'h0F0, 16'h7777, 0, 1'b0);
`ifdef READ_SEQ_AUTOPRECHARGE_EN
        chk("pre_trace", 32'(pre_cnt_a), 32'd0);
`else
        chk("pre_trace", 32'(pre_cnt_a), 32'd7);
`endif

        // Instance B: T_RCD=3, CAS_LAT=3, T_RP=1.
        ba = 2'd1; row = 13'h1234; col = 9'h033; rdy = 1'b1; dq = 16'h0000; en_b = 1'b1;
        tick();
        chk("b_act", 32'(cmd_b), 32'(C_ACT));
        chk("b_row", 32'(sd_a_b), 32'(13'h1234));
        en_b = 1'b0;
        tick();
        chk("b_rcd1", 32'(cmd_b), 32'(C_NOP));
        tick();
        chk("b_rcd2", 32'(cmd_b), 32'(C_NOP));
        tick();
        chk("b_rd", 32'(cmd_b), 32'(C_RD));
        chk("b_rd_addr", 32'(sd_a_b), 32'({2'b00, AP, 1'b0, 9'h033}));
        dq = 16'h1111;
        tick();
        dq = 16'h2222;
        tick();
        dq = 16'h4444;
        tick();
        chk("b_cap_valid", 32'(valid_b), 32'(1'b0));
        dq = 16'hD00D;
        tick();
        chk("b_data", 32'(dout_b), 32'(16'hD00D));
        chk("b_valid", 32'(valid_b), 32'(1'b1));
        dq = 16'h3333;
        tick();
        chk("b_next", 32'(next_b), 32'(1'b1));
`ifdef READ_SEQ_AUTOPRECHARGE_EN
        chk("b_idle_cmd", 32'(cmd_b), 32'(C_DES));
        chk("b_idle_busy", 32'(busy_b), 32'(1'b0));
`else
        chk("b_pre", 32'(cmd_b), 32'(C_PRE));
        tick();
        chk("b_idle_cmd", 32'(cmd_b), 32'(C_DES));
        chk("b_idle_busy", 32'(busy_b), 32'(1'b0));
        chk("b_idle_next", 32'(next_b), 32'(1'b0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_read_sequencer.md
SDRAM_READ_SEQUENCER -- requirements
Module: sdram_read_sequencer

Interface
REQ-001 Parameter T_RCD, default 2: clock cycles from ACTIVE to READ.
REQ-002 Parameter CAS_LAT, default 2: clock cycles from READ to valid DQ.
REQ-003 Parameter T_RP, default 2: clock cycles from PRECHARGE to next ACTIVE.
REQ-004 CLK_48MHZ  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 ENABLE  in  1  sampled in IDLE; high starts one read transaction.
REQ-007 BA_IN  in  2  bank of the read address.
REQ-008 ROW_IN  in  13  row of the read address.
REQ-009 COL_IN  in  9  column of the read address.
REQ-010 NEXT  out  1  one-cycle pulse that advances the upstream read-address counter.
REQ-011 CS_N, RAS_N, CAS_N, WE_N  out  1 each  SDRAM command lines.
REQ-012 SD_BA  out  2  SDRAM bank address.
REQ-013 SD_A  out  13  SDRAM address bus.
REQ-014 SD_DQ_IN  in  16  SDRAM read data.
REQ-015 DATA_OUT  out  16  captured word.
REQ-016 DATA_VALID  out  1  DATA_OUT holds an unaccepted word.
REQ-017 DATA_READY  in  1  downstream accepts the word when DATA_VALID and DATA_READY are both high.
REQ-018 BUSY  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ACTIVATE, WAIT_RCD, READ, WAIT_CAS, CAPTURE, HOLD, PRECHARGE, WAIT_RP.
REQ-020 IDLE with ENABLE=1: latch BA_IN/ROW_IN/COL_IN into internal registers and go to ACTIVATE; address inputs are ignored after this point.
REQ-021 ACTIVATE: drive command ACTIVE (RAS_N=0, CAS_N=1, WE_N=1, CS_N=0) for one cycle, with SD_BA = latched bank and SD_A = latched row.
REQ-022 WAIT_RCD: drive NOP (CS_N=0, others 1) for T_RCD-1 cycles, then go to READ.
REQ-023 READ: drive RAS_N=1, CAS_N=0, WE_N=1 for one cycle.
  - SD_A[8:0] = latched column.
  - SD_A[10] = 0, or per REQ-036.
  - All other SD_A bits = 0.
REQ-024 WAIT_CAS: NOP for CAS_LAT-1 cycles; CAPTURE registers SD_DQ_IN into DATA_OUT exactly CAS_LAT cycles after the READ cycle.
REQ-025 CAPTURE: set DATA_VALID=1 and go to HOLD.
REQ-026 HOLD: remain while DATA_READY=0, with DATA_OUT and DATA_VALID stable.
  - On the handshake, clear DATA_VALID next cycle and pulse NEXT high for exactly that one cycle.
  - Then go to PRECHARGE.
REQ-027 PRECHARGE: drive RAS_N=0, CAS_N=1, WE_N=0 for one cycle, with SD_A[10]=0 and SD_BA = latched bank.
REQ-028 WAIT_RP: NOP for T_RP-1 cycles, then go to IDLE.
REQ-029 NEXT is never asserted other than by REQ-026; exactly one NEXT pulse per accepted word.
REQ-030 DATA_READY high before DATA_VALID has no effect.
REQ-031 Delay counters are sized to hold max(T_RCD, CAS_LAT, T_RP); a parameter value of 1 means zero wait cycles.
REQ-032 An ENABLE change outside IDLE has no effect on the current transaction.

Reset
REQ-033 RESET=0 forces, asynchronously:
  - state = IDLE;
  - CS_N=1, RAS_N=1, CAS_N=1, WE_N=1;
  - SD_BA=0, SD_A=0;
  - DATA_OUT=0, DATA_VALID=0, NEXT=0, BUSY=0;
  - latched address and counters = 0.
REQ-034 Reset asserted mid-transaction abandons that transaction with no NEXT pulse and no precharge issued.
REQ-035 After reset release, the first possible ACTIVE is one cycle after ENABLE is sampled high.

Configuration
REQ-036 With macro READ_SEQ_AUTOPRECHARGE_EN defined:
  - READ drives SD_A[10]=1 (read with auto-precharge);
  - HOLD exits directly to WAIT_RP, skipping PRECHARGE.
  Without the macro:
  - SD_A[10]=0 and explicit PRECHARGE is issued.

Structure
REQ-037 A shared package holds:
  - the state encoding enum;
  - the 4-bit command constants CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_PRECHARGE, CMD_DESELECT as {CS_N,RAS_N,CAS_N,WE_N};
  - address width constants 2/13/9/16.
REQ-038 One sub-module, sdram_cmd_encoder, maps a command constant to registered CS_N/RAS_N/CAS_N/WE_N outputs.

Verification
REQ-039 Reset mid-WAIT_CAS, then release: all outputs at REQ-033 values, no NEXT pulse, FSM in IDLE.
REQ-040 Defaults, ENABLE=1, BA_IN=2, ROW_IN=0x1ABC, COL_IN=0x05F, SD_DQ_IN=0xBEEF at the CAS_LAT cycle, DATA_READY=1 -> expected sequence:
  - ACTIVE with SD_BA=2, SD_A=0x1ABC;
  - READ 2 cycles later with SD_A=0x005F;
  - DATA_OUT=0xBEEF;
  - one NEXT pulse;
  - PRECHARGE;
  - IDLE.
REQ-041 DATA_READY held low for 10 cycles after DATA_VALID -> DATA_OUT stable for 10 cycles; NEXT low throughout; NEXT pulses once after DATA_READY rises.
REQ-042 ENABLE held high for 4 transactions, address inputs changed mid-transaction -> each READ uses the address latched in IDLE; exactly 4 NEXT pulses.
REQ-043 T_RCD=3, CAS_LAT=3, T_RP=1 -> ACTIVE-to-READ spacing of 3 cycles, capture on the 3rd cycle after READ, IDLE the cycle after PRECHARGE.
REQ-044 Build with READ_SEQ_AUTOPRECHARGE_EN -> READ shows SD_A[10]=1 and no PRECHARGE command appears in the command trace.
